cmn_stream_demux: RTL and testbench

Valid/ready 1-to-N stream router. It takes one input message stream and steers each packet to exactly one of p_nports output streams, chosen by a destination select on the packet's first beat. Two-entry internal buffering gives full throughput with registered in_rdy. It sits downstream of shared producers, on the far side of the cmn_Mux* select paths, to fan results out to per-unit consumers.

---
 rtl/cmn_stream_demux.sv | 240 ++++++++++++++++++++++++
 tb/tb_cmn_stream_demux.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmn_stream_demux.sv
// Valid/ready 1-to-N packet router with a two-entry output buffer and registered outputs.
// Optional build macro CMN_STREAM_DEMUX_STATS_EN enables the saturating dropped-beat counter.
module cmn_stream_demux #(
    parameter int p_nbits  = 32,
    parameter int p_nports = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_val,
    output logic                in_rdy,
    input  logic [p_nbits-1:0]  in_msg,
    input  logic [2:0]          in_sel,
    input  logic                in_last,
    output logic [p_nports-1:0] out_val,
    input  logic [p_nports-1:0] out_rdy,
    output logic [p_nbits-1:0]  out_msg,
    output logic                out_last,
    output logic                drop,
    output logic [15:0]         drop_count
);

    localparam logic [3:0] NPORTS_C = 4'(p_nports);

    typedef enum logic [0:0] {
        ST_HEAD = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [2:0]           dest_r;
    logic                 drop_pkt_r;

    logic [2:0]           beat_dest_s;
    logic                 beat_drop_s;
    logic                 accept_s;
    logic                 enq_s;
    logic                 deq_s;

    logic [p_nbits-1:0]   msg_mem_r  [2];
    logic                 last_mem_r [2];
    logic [2:0]           dest_mem_r [2];
    logic                 wr_ptr_r;
    logic                 rd_ptr_r;
    logic [1:0]           count_r;

    logic                 wr_ptr_s;
    logic                 rd_ptr_s;
    logic [1:0]           count_s;
    logic [p_nbits-1:0]   head_msg_s;
    logic                 head_last_s;
    logic [2:0]           head_dest_s;
    logic [p_nports-1:0]  out_val_s;

    logic                 in_rdy_r;
    logic [p_nports-1:0]  out_val_r;
    logic [p_nbits-1:0]   out_msg_r;
    logic                 out_last_r;
    logic                 drop_r;

    assign accept_s = in_val && in_rdy_r;
    assign enq_s    = accept_s && !beat_drop_s;
    assign deq_s    = |(out_val_r & out_rdy);

    // Packet framing state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_HEAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Framing next state: every accepted beat's last flag decides whether a packet is open.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_HEAD: begin
                if (accept_s && !in_last) begin
                    state_nxt_s = ST_BODY;
                end else begin
                    state_nxt_s = ST_HEAD;
                end
            end
            ST_BODY: begin
                if (accept_s && in_last) begin
                    state_nxt_s = ST_HEAD;
                end else begin
                    state_nxt_s = ST_BODY;
                end
            end
            default: state_nxt_s = ST_HEAD;
        endcase
    end

    // Per-beat routing decision: head beats use in_sel live, body beats reuse the latched choice.
    always_comb begin
        beat_dest_s = dest_r;
        beat_drop_s = drop_pkt_r;
        case (state_r)
            ST_HEAD: begin
                beat_dest_s = in_sel;
                beat_drop_s = ({1'b0, in_sel} >= NPORTS_C);
            end
            ST_BODY: begin
                beat_dest_s = dest_r;
                beat_drop_s = drop_pkt_r;
            end
            default: begin
                beat_dest_s = 3'd0;
                beat_drop_s = 1'b0;
            end
        endcase
    end

    // Latch destination and drop decision on each accepted head beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            dest_r     <= 3'd0;
            drop_pkt_r <= 1'b0;
        end else if (accept_s && (state_r == ST_HEAD)) begin
            dest_r     <= in_sel;
            drop_pkt_r <= beat_drop_s;
        end else begin
            dest_r     <= dest_r;
            drop_pkt_r <= drop_pkt_r;
        end
    end

    // Buffer storage writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                msg_mem_r[i]  <= '0;
                last_mem_r[i] <= 1'b0;
                dest_mem_r[i] <= 3'd0;
            end
        end else if (enq_s) begin
            msg_mem_r[wr_ptr_r]  <= in_msg;
            last_mem_r[wr_ptr_r] <= in_last;
            dest_mem_r[wr_ptr_r] <= beat_dest_s;
        end else begin
            msg_mem_r[wr_ptr_r]  <= msg_mem_r[wr_ptr_r];
            last_mem_r[wr_ptr_r] <= last_mem_r[wr_ptr_r];
            dest_mem_r[wr_ptr_r] <= dest_mem_r[wr_ptr_r];
        end
    end

    // Post-update buffer view; an entry written this cycle bypasses storage so outputs can register it.
    always_comb begin
        wr_ptr_s    = wr_ptr_r ^ enq_s;
        rd_ptr_s    = rd_ptr_r ^ deq_s;
        count_s     = count_r + {1'b0, enq_s} - {1'b0, deq_s};
        head_msg_s  = msg_mem_r[rd_ptr_s];
        head_last_s = last_mem_r[rd_ptr_s];
        head_dest_s = dest_mem_r[rd_ptr_s];
        if (enq_s && (wr_ptr_r == rd_ptr_s)) begin
            head_msg_s  = in_msg;
            head_last_s = in_last;
            head_dest_s = beat_dest_s;
        end else begin
            head_msg_s  = msg_mem_r[rd_ptr_s];
            head_last_s = last_mem_r[rd_ptr_s];
            head_dest_s = dest_mem_r[rd_ptr_s];
        end
    end

    // One-hot valid for the next head entry.
    always_comb begin
        out_val_s = '0;
        if (count_s != 2'd0) begin
            for (int k = 0; k < p_nports; k++) begin
                out_val_s[k] = (head_dest_s == 3'(k));
            end
        end else begin
            out_val_s = '0;
        end
    end

    // Buffer pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            count_r  <= count_s;
        end
    end

    // Registered output stage; payload holds its last value while the buffer is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_rdy_r   <= 1'b1;
            out_val_r  <= '0;
            out_msg_r  <= '0;
            out_last_r <= 1'b0;
            drop_r     <= 1'b0;
        end else begin
            in_rdy_r  <= (count_s != 2'd2);
            out_val_r <= out_val_s;
            drop_r    <= accept_s && beat_drop_s;
            if (count_s != 2'd0) begin
                out_msg_r  <= head_msg_s;
                out_last_r <= head_last_s;
            end else begin
                out_msg_r  <= out_msg_r;
                out_last_r <= out_last_r;
            end
        end
    end

    assign in_rdy   = in_rdy_r;
    assign out_val  = out_val_r;
    assign out_msg  = out_msg_r;
    assign out_last = out_last_r;
    assign drop     = drop_r;

`ifdef CMN_STREAM_DEMUX_STATS_EN
    logic [15:0] drop_count_r;

    // Saturating dropped-beat counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_r <= 16'd0;
        end else if (accept_s && beat_drop_s && (drop_count_r != 16'hFFFF)) begin
            drop_count_r <= drop_count_r + 16'd1;
        end else begin
            drop_count_r <= drop_count_r;
        end
    end

    assign drop_count = drop_count_r;
`else
    assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_cmn_stream_demux.sv
// Scoreboard bench for cmn_stream_demux: directed scenarios plus randomized traffic checked
// against a packet-level reference model.
module tb_cmn_stream_demux;

    localparam int NP = 4;
    localparam int NB = 32;

    logic            clk;
    logic            reset;
    logic            in_val;
    logic            in_rdy;
    logic [NB-1:0]   in_msg;
    logic [2:0]      in_sel;
    logic            in_last;
    logic [NP-1:0]   out_val;
    logic [NP-1:0]   out_rdy;
    logic [NB-1:0]   out_msg;
    logic            out_last;
    logic            drop;
    logic [15:0]     drop_count;

    cmn_stream_demux #(.p_nbits(NB), .p_nports(NP)) dut (
        .clk(clk), .reset(reset),
        .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg), .in_sel(in_sel), .in_last(in_last),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_last(out_last),
        .drop(drop), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            port;
        logic [NB-1:0] msg;
        logic          last;
    } beat_t;

    beat_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;

    // reference model state
    bit          mon_en   = 0;
    bit          rdy_neg  = 0;
    bit          in_body  = 0;
    int          cur_port = 0;
    bit          cur_drop = 0;
    bit          exp_drop = 0;
    logic [15:0] exp_dc   = 16'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: applies the routing rules to each accepted beat.
    always @(posedge clk) begin
        if (reset) begin
            sb.delete();
            in_body  = 0;
            exp_drop = 0;
            exp_dc   = 16'd0;
            mon_en   = 1;
        end else begin
            exp_drop = 0;
            if (in_val && rdy_neg) begin
                if (!in_body) begin
                    cur_port = int'(in_sel);
                    cur_drop = (int'(in_sel) >= NP);
                end
                if (cur_drop) begin
                    exp_drop = 1;
`ifdef CMN_STREAM_DEMUX_STATS_EN
                    if (exp_dc != 16'hFFFF) exp_dc = exp_dc + 16'd1;
`endif
                end else begin
                    sb.push_back('{port: cur_port, msg: in_msg, last: in_last});
                end
                in_body = !in_last;
            end
        end
    end

    // Monitor: compares DUT outputs to the scoreboard head, pops on each output transfer.
    always @(negedge clk) begin
        logic [NP-1:0] exp_v;
        rdy_neg = in_rdy;
        if (mon_en) begin
            chk("in_rdy", 64'(in_rdy), 64'(sb.size() < 2));
            chk("drop", 64'(drop), 64'(exp_drop));
            chk("drop_count", 64'(drop_count), 64'(exp_dc));
            if (sb.size() == 0) begin
                chk("out_val_idle", 64'(out_val), 64'd0);
            end else begin
                exp_v = '0;
                exp_v[sb[0].port] = 1'b1;
                chk("out_val", 64'(out_val), 64'(exp_v));
                chk("out_msg", 64'(out_msg), 64'(sb[0].msg));
                chk("out_last", 64'(out_last), 64'(sb[0].last));
                if ((out_val & out_rdy) != '0) void'(sb.pop_front());
            end
        end
    end

    // Tasks start and end at posedge + 1.
    task automatic idle_inputs();
        in_val  = 1'b0;
        in_sel  = 3'($urandom);
        in_last = 1'($urandom);
        in_msg  = NB'($urandom);
    endtask

    task automatic send_beat(input logic [NB-1:0] msg, input logic [2:0] sel, input logic last);
        bit acc = 0;
        bit now;
        in_val  = 1'b1;
        in_msg  = msg;
        in_sel  = sel;
        in_last = last;
        for (int i = 0; i < 200 && !acc; i++) begin
            now = in_rdy;
            @(posedge clk);
            #1;
            acc = now;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        idle_inputs();
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        idle_inputs();
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    bit rand_rdy = 0;
    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_rdy = NP'($urandom);
    end

    task automatic drain();
        out_rdy = '1;
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        reset   = 1'b1;
        out_rdy = '1;
        idle_inputs();
        @(posedge clk);
        #1;
        do_reset(2);
        repeat (2) @(posedge clk);
        #1;

        // single-beat packets to every port
        for (int p = 0; p < 4; p++) send_beat(NB'(32'hA0 + p), 3'(p), 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // four-beat packet: body beats ignore in_sel
        send_beat(32'h1000, 3'd2, 1'b0);
        send_beat(32'h1001, 3'd0, 1'b0);
        send_beat(32'h1002, 3'd0, 1'b0);
        send_beat(32'h1003, 3'd0, 1'b1);
        send_beat(32'h1004, 3'd1, 1'b1);
        drain();

        // stalled port 1: two beats buffer, third waits
        out_rdy = 4'b1101;
        send_beat(32'hB0, 3'd1, 1'b1);
        send_beat(32'hB1, 3'd1, 1'b1);
        in_val = 1'b1; in_msg = 32'hB2; in_sel = 3'd1; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("full_in_rdy", 64'(in_rdy), 64'd0);
            @(posedge clk);
            #1;
        end
        out_rdy = '1;
        send_beat(32'hB2, 3'd1, 1'b1);
        drain();

        // invalid destination drops the whole packet
        send_beat(32'hC0, 3'd6, 1'b0);
        send_beat(32'hC1, 3'd0, 1'b1);
        send_beat(32'hC2, 3'd1, 1'b1);
        drain();
`ifdef CMN_STREAM_DEMUX_STATS_EN
        chk("drop_count_2", 64'(drop_count), 64'd2);
`else
        chk("drop_count_off", 64'(drop_count), 64'd0);
`endif

        // reset mid-packet with two beats buffered
        out_rdy = '0;
        send_beat(32'hD0, 3'd2, 1'b0);
        send_beat(32'hD1, 3'd2, 1'b0);
        do_reset(1);
        chk("rst_out_val", 64'(out_val), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd1);
        out_rdy = '1;
        send_beat(32'hD2, 3'd3, 1'b1);
        drain();

        // randomized traffic with random backpressure
        rand_rdy = 1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(3, 0) == 0) begin
                idle_inputs();
                @(posedge clk);
                #1;
            end
            send_beat(NB'($urandom), 3'($urandom_range(7, 0)), ($urandom_range(2, 0) == 0));
        end
        rand_rdy = 0;
        @(posedge clk);
        #1;
        drain();

`ifdef CMN_STREAM_DEMUX_STATS_EN
        // counter saturation
        do_reset(1);
        in_val = 1'b1; in_sel = 3'd7; in_last = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        idle_inputs();
        @(posedge clk);
        #1;
        chk("drop_count_sat", 64'(drop_count), 64'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
